// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared FSM encoding, default raster timing and framebuffer geometry
// for the VGA framebuffer fetch arbiter.
package vga_fb_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 525;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;

    localparam int DEF_SCALE_LOG2  = 3;
    localparam int DEF_FB_COLS     = DEF_ACTIVE_COLS >> DEF_SCALE_LOG2;
    localparam int DEF_FB_ROWS     = DEF_ACTIVE_ROWS >> DEF_SCALE_LOG2;
    localparam int DEF_DATA_W      = 3;
    localparam int DEF_ADDR_W      = 13;

    typedef logic [DEF_DATA_W-1:0] cell_t;

endpackage

// File: rtl/vga_line_buf.sv
// vga_line_buf: one framebuffer row of cells, one write port and one registered
// read port that returns zero when the read is not enabled.
module vga_line_buf #(
    parameter int DEPTH  = 80,
    parameter int DATA_W = 3,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately not reset so it can map to RAM;
    // only the read register, which drives the pixel output, has a reset.
    always_ff @(posedge i_Clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_idx];
        else            rd_data <= '0;
    end

endmodule

// File: rtl/vga_fb_fetch_arbiter.sv
// vga_fb_fetch_arbiter: shares a single-port framebuffer RAM between per-row line
// fetches in hblank and a pixel writer. Define VGA_FETCH_ERR_EN for o_Fetch_Err.
module vga_fb_fetch_arbiter
    import vga_fb_pkg::*;
#(
    parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int SCALE_LOG2  = DEF_SCALE_LOG2,
    parameter int FB_COLS     = DEF_FB_COLS,
    parameter int FB_ROWS     = DEF_FB_ROWS,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [9:0]        i_Col_Count,
    input  logic [9:0]        i_Row_Count,
    input  logic              i_Wr_Req,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [DATA_W-1:0] i_Wr_Data,
    output logic              o_Wr_Ack,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_We,
    output logic [DATA_W-1:0] o_Mem_WData,
    input  logic [DATA_W-1:0] i_Mem_RData,
    output logic [DATA_W-1:0] o_Pix_Data,
    output logic              o_Pix_Valid,
`ifdef VGA_FETCH_ERR_EN
    output logic              o_Fetch_Err,
`endif
    output logic              o_Fetch_Busy
);

    localparam int              K_W         = $clog2(FB_COLS);
    localparam logic [K_W-1:0]  K_LAST      = K_W'(FB_COLS - 1);
    localparam logic [9:0]      ACT_COLS    = 10'(ACTIVE_COLS);
    localparam logic [9:0]      ACT_ROWS    = 10'(ACTIVE_ROWS);
    localparam logic [9:0]      LAST_ROW    = 10'(TOTAL_ROWS - 1);
    localparam logic [10:0]     ACT_ROWS_11 = 11'(ACTIVE_ROWS);
    localparam logic [ADDR_W-1:0] FB_COLS_A = ADDR_W'(FB_COLS);
    // A geometry that cannot fit the fetch in hblank never fetches, so it shows up on screen.
    localparam bit GEOM_OK = (FB_COLS == (ACTIVE_COLS >> SCALE_LOG2))
                          && (FB_ROWS == (ACTIVE_ROWS >> SCALE_LOG2))
                          && (FB_COLS < TOTAL_COLS - ACTIVE_COLS)
                          && ((1 << ADDR_W) >= FB_COLS * FB_ROWS);

    state_t            state;
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] base;
    logic              cap_en;
    logic [K_W-1:0]    cap_idx;
    logic [10:0]       row_p1;
    logic              trigger;
    logic [ADDR_W-1:0] trig_base;
    logic              in_active;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        row_p1    = {1'b0, i_Row_Count} + 11'd1;
        trigger   = 1'b0;
        trig_base = '0;
        if (GEOM_OK && i_Col_Count == ACT_COLS) begin
            if (row_p1[SCALE_LOG2-1:0] == '0 && row_p1 < ACT_ROWS_11) begin
                trigger   = 1'b1;
                trig_base = ADDR_W'(row_p1 >> SCALE_LOG2) * FB_COLS_A;
            end else if (i_Row_Count == LAST_ROW) begin
                trigger   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= IDLE;
            k            <= '0;
            base         <= '0;
            cap_en       <= 1'b0;
            cap_idx      <= '0;
            o_Fetch_Busy <= 1'b0;
        end else begin
            cap_en  <= (state == FETCH);
            cap_idx <= k;
            case (state)
                IDLE: if (trigger) begin
                    state        <= FETCH;
                    k            <= '0;
                    base         <= trig_base;
                    o_Fetch_Busy <= 1'b1;
                end
                FETCH: if (k == K_LAST) state <= DRAIN;
                       else             k     <= k + K_W'(1);
                DRAIN: begin
                    state        <= IDLE;
                    o_Fetch_Busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The writer is granted combinationally so a held request is acked exactly once.
    always_comb begin
        o_Mem_Addr  = '0;
        o_Mem_We    = 1'b0;
        o_Mem_WData = '0;
        o_Wr_Ack    = 1'b0;
        if (!i_Rst) begin
            case (state)
                FETCH: o_Mem_Addr = base + ADDR_W'(k);
                IDLE: if (!trigger && i_Wr_Req) begin
                    o_Mem_Addr  = i_Wr_Addr;
                    o_Mem_We    = 1'b1;
                    o_Mem_WData = i_Wr_Data;
                    o_Wr_Ack    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_active = (i_Col_Count < ACT_COLS) && (i_Row_Count < ACT_ROWS);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) o_Pix_Valid <= 1'b0;
        else       o_Pix_Valid <= in_active;
    end

    vga_line_buf #(
        .DEPTH  (FB_COLS),
        .DATA_W (DATA_W),
        .IDX_W  (K_W)
    ) u_line_buf (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .wr_en   (cap_en),
        .wr_idx  (cap_idx),
        .wr_data (i_Mem_RData),
        .rd_en   (in_active),
        .rd_idx  (K_W'(i_Col_Count >> SCALE_LOG2)),
        .rd_data (o_Pix_Data)
    );

`ifdef VGA_FETCH_ERR_EN
    // Sticky: a fetch overlapping a new trigger or the start of a visible line.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Fetch_Err <= 1'b0;
        end else if (state != IDLE &&
                     (trigger || (i_Col_Count == '0 && i_Row_Count < ACT_ROWS))) begin
            o_Fetch_Err <= 1'b1;
        end
    end
`else
    // Without the monitor, fetch overruns are not reported.
`endif

endmodule

// File: doc/vga_fb_fetch_arbiter.md
Name: vga_fb_fetch_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters: the VGA scan-out and a pixel writer such as a UART-driven draw engine.
- The framebuffer is FB_COLS x FB_ROWS cells. Each cell is DATA_W bits and is upscaled 2^SCALE_LOG2 in both axes onto the 640x480 raster.
- During horizontal blanking the block fetches the next framebuffer row into an internal line buffer. It serves writer requests in all other cycles.
- It sits between the sync generator's column/row counters and the colour output stage.

Parameters:
- TOTAL_COLS, 800, raster columns per line, blanking included.
- TOTAL_ROWS, 525, raster lines per frame, blanking included.
- ACTIVE_COLS, 640, visible columns.
- ACTIVE_ROWS, 480, visible rows.
- SCALE_LOG2, 3, log2 of the upscale factor (8x8 pixels per cell).
- FB_COLS, 80, cells per framebuffer row; must equal ACTIVE_COLS >> SCALE_LOG2.
- FB_ROWS, 60, framebuffer rows; must equal ACTIVE_ROWS >> SCALE_LOG2.
- DATA_W, 3, bits per cell.
- ADDR_W, 13, framebuffer address width; must satisfy 2^ADDR_W >= FB_COLS*FB_ROWS.

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock).
- i_Rst  in  1  synchronous reset, active-high.
- i_Col_Count  in  10  current raster column from the sync generator.
- i_Row_Count  in  10  current raster row from the sync generator.
- i_Wr_Req  in  1  writer request; held high until o_Wr_Ack.
- i_Wr_Addr  in  ADDR_W  writer cell address (row*FB_COLS+col).
- i_Wr_Data  in  DATA_W  writer cell value.
- o_Wr_Ack  out  1  one-cycle pulse: write issued this cycle.
- o_Mem_Addr  out  ADDR_W  RAM address.
- o_Mem_We  out  1  RAM write enable.
- o_Mem_WData  out  DATA_W  RAM write data.
- i_Mem_RData  in  DATA_W  RAM read data; valid 1 cycle after the address.
- o_Pix_Data  out  DATA_W  cell value for the current pixel.
- o_Pix_Valid  out  1  o_Pix_Data lies in the active area.
- o_Fetch_Busy  out  1  a fetch is in progress.

Behaviour:
Reset:
- i_Rst is synchronous, active-high, one clock domain.
- On reset: state=IDLE; o_Wr_Ack, o_Mem_We, o_Pix_Valid, o_Fetch_Busy = 0; o_Mem_Addr = 0; o_Pix_Data = 0; line buffer is not cleared.

Fetch trigger (combinational, evaluated each cycle):
- Condition: i_Col_Count==ACTIVE_COLS AND one of:
  - ((i_Row_Count+1) mod 2^SCALE_LOG2)==0 and i_Row_Count+1 < ACTIVE_ROWS; target row = (i_Row_Count+1)>>SCALE_LOG2.
  - i_Row_Count==TOTAL_ROWS-1; target row = 0.

State machine:
- IDLE:
  - Trigger true: go to FETCH, k=0, base=target*FB_COLS, o_Fetch_Busy=1.
  - Else if i_Wr_Req: drive o_Mem_Addr=i_Wr_Addr, o_Mem_We=1, o_Mem_WData=i_Wr_Data, o_Wr_Ack=1 the same cycle. Stay in IDLE, so back-to-back writes run 1 per cycle.
  - Trigger and i_Wr_Req in the same cycle: the fetch wins and the write waits with no ack.
- FETCH:
  - Each cycle: o_Mem_Addr=base+k, We=0.
  - Data captured the following cycle into linebuf[k].
  - After k==FB_COLS-1 is issued, go to DRAIN.
- DRAIN:
  - Capture the last word, clear o_Fetch_Busy, go to IDLE.

Fetch timing:
- Total fetch = FB_COLS+1 cycles (81), which fits the 160-cycle hblank.
- Writer worst-case wait = 81 cycles. No writes occur during FETCH or DRAIN.

Reset mid-fetch:
- Abort to IDLE. The partial line buffer is retained; the next trigger refills it.

Pixel output:
- 1-cycle latency, registered.
- o_Pix_Valid = (col<ACTIVE_COLS && row<ACTIVE_ROWS), delayed 1 cycle.
- o_Pix_Data = valid ? linebuf[col>>SCALE_LOG2] : 0, delayed 1 cycle.

Width and wrap rules:
- Address arithmetic is ADDR_W wide, unsigned.
- The row+1 compare uses an 11-bit intermediate, so row 1023 cannot wrap.
- Writer addresses >= FB_COLS*FB_ROWS are still acked. The RAM wraps them, and the block does not check.

Optional Feature:
- Macro: VGA_FETCH_ERR_EN.
- Defined:
  - Adds output o_Fetch_Err (1 bit), reset 0.
  - o_Fetch_Err sets sticky when a trigger occurs while state != IDLE, or when state != IDLE while i_Col_Count==0 and the row is active.
  - Cleared only by i_Rst.
- Not defined: the port is absent and there is no error logic.

Decomposition:
- Package vga_fb_pkg holds:
  - state enum {IDLE, FETCH, DRAIN};
  - the default raster constants (800/525/640/480);
  - the FB geometry constants;
  - the cell data typedef (DATA_W bits).
- One sub-module: vga_line_buf. It is a FB_COLS x DATA_W register/BRAM array with 1 write port and 1 registered read port.

Test Plan:
- Reset then free-run one frame, writer idle: at row 524 col 640 o_Fetch_Busy rises, o_Mem_Addr steps 0..79, busy falls 81 cycles later.
- Preload RAM cell (row 1, col 5)=3'b101: at raster row 8, cols 40..47, o_Pix_Data=5 with o_Pix_Valid=1, both one cycle later.
- Hold i_Wr_Req (addr 100, data 2) across the row-7 col-640 trigger: no ack during the 81 fetch cycles; ack on the first IDLE cycle with o_Mem_We=1, o_Mem_Addr=100.
- Continuous writer requests during active video: one ack per cycle, o_Mem_WData tracks i_Wr_Data, no fetch disturbance.
- Assert i_Rst at fetch cycle k=40: next cycle state=IDLE, o_Fetch_Busy=0; the following trigger refetches all 80 cells correctly.
- With VGA_FETCH_ERR_EN, force a trigger during FETCH: o_Fetch_Err=1 and it stays 1 until i_Rst.
